// File: rtl/run_detector_if.sv
// Serial-stream bus between a bit source and the run detector: the sample and
// control inputs from the source, plus the detection status returned to it.
interface run_detector_if #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
);
  logic             in;
  logic             in_valid;
  logic             clear;
  logic             en_zero;
  logic             en_one;
  logic             out;
  logic             out_bit;
  logic [LEN_W-1:0] run_len;
  logic             hit;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output in, in_valid, clear, en_zero, en_one,
    input  out, out_bit, run_len, hit, hit_count
  );

  modport slave (
    input  in, in_valid, clear, en_zero, en_one,
    output out, out_bit, run_len, hit, hit_count
  );
endinterface

// File: rtl/run_detector.sv
// Run-length detector: flags RUN_LEN or more consecutive equal valid samples,
// with per-polarity enables, a saturating run length, a hit strobe and a hit counter.
module run_detector #(
  parameter int RUN_LEN = 4,
  parameter int LEN_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  run_detector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HIT   = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] RUN_MAX = LEN_W'(RUN_LEN);

  state_t           state, state_d;
  logic             last_bit, last_bit_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic             in_pol_en;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_bit    <= 1'b0;
      run_len_q   <= '0;
      hit_q       <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state       <= state_d;
      last_bit    <= last_bit_d;
      run_len_q   <= run_len_d;
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
    end
  end

  // The enable that matters for a hit is the one of the run being extended,
  // i.e. the polarity of the incoming bit at the completing edge.
  assign in_pol_en = bus.in ? bus.en_one : bus.en_zero;

  // NOTE: every signal gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state;
    last_bit_d  = last_bit;
    run_len_d   = run_len_q;
    hit_d       = 1'b0;
    hit_count_d = hit_count_q;

    if (bus.clear) begin
      state_d     = IDLE;
      last_bit_d  = 1'b0;
      run_len_d   = '0;
      hit_count_d = '0;
    end else if (bus.in_valid) begin
      if (state == IDLE || bus.in != last_bit) begin
        state_d    = COUNT;
        last_bit_d = bus.in;
        run_len_d  = LEN_W'(1);
      end else if (state == COUNT) begin
        run_len_d = run_len_q + 1'b1;
        if (run_len_d == RUN_MAX) begin
          state_d = HIT;
          if (in_pol_en) begin
            hit_d       = 1'b1;
            hit_count_d = hit_count_q + 1'b1;
          end
        end
      end
      // Same bit while in HIT: run length stays saturated, nothing re-fires.
    end
  end

  // Enables are applied combinationally so they take effect mid-run.
  always_comb begin
    bus.out       = (state == HIT) && (last_bit ? bus.en_one : bus.en_zero);
    bus.out_bit   = last_bit;
    bus.run_len   = run_len_q;
    bus.hit       = hit_q;
    bus.hit_count = hit_count_q;
  end

endmodule

// File: tb/tb_run_detector.sv
// Directed bench for run_detector: three instances (RUN_LEN=4, RUN_LEN=6, and
// RUN_LEN=4 with a 2-bit hit counter) driven through their own bus interfaces.
module tb_run_detector;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  run_detector_if #(.LEN_W(8), .CNT_W(8)) ia ();
  run_detector_if #(.LEN_W(8), .CNT_W(8)) ib ();
  run_detector_if #(.LEN_W(8), .CNT_W(2)) ic ();

  run_detector #(.RUN_LEN(4), .LEN_W(8), .CNT_W(8)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
  run_detector #(.RUN_LEN(6), .LEN_W(8), .CNT_W(8)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));
  run_detector #(.RUN_LEN(4), .LEN_W(8), .CNT_W(2)) dut_c (.clk(clk), .reset_n(reset_n), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic o, input logic b, input int len,
                       input logic h, input int c);
    check({tag, ".out"},       32'(ia.out),       32'(o));
    check({tag, ".out_bit"},   32'(ia.out_bit),   32'(b));
    check({tag, ".run_len"},   32'(ia.run_len),   32'(len));
    check({tag, ".hit"},       32'(ia.hit),       32'(h));
    check({tag, ".hit_count"}, 32'(ia.hit_count), 32'(c));
  endtask

  task automatic chk_b(input string tag, input logic o, input logic b, input int len,
                       input logic h, input int c);
    check({tag, ".out"},       32'(ib.out),       32'(o));
    check({tag, ".out_bit"},   32'(ib.out_bit),   32'(b));
    check({tag, ".run_len"},   32'(ib.run_len),   32'(len));
    check({tag, ".hit"},       32'(ib.hit),       32'(h));
    check({tag, ".hit_count"}, 32'(ib.hit_count), 32'(c));
  endtask

  task automatic chk_c(input string tag, input logic o, input logic b, input int len,
                       input logic h, input int c);
    check({tag, ".out"},       32'(ic.out),       32'(o));
    check({tag, ".out_bit"},   32'(ic.out_bit),   32'(b));
    check({tag, ".run_len"},   32'(ic.run_len),   32'(len));
    check({tag, ".hit"},       32'(ic.hit),       32'(h));
    check({tag, ".hit_count"}, 32'(ic.hit_count), 32'(c));
  endtask

  // Each step applies one cycle of stimulus, returns at the following falling
  // edge and drops in_valid/clear again.
  task automatic step_a(input logic v, input logic b, input logic clr);
    ia.in_valid = v; ia.in = b; ia.clear = clr;
    @(posedge clk); @(negedge clk);
    ia.in_valid = 1'b0; ia.clear = 1'b0;
  endtask

  task automatic step_b(input logic v, input logic b, input logic clr);
    ib.in_valid = v; ib.in = b; ib.clear = clr;
    @(posedge clk); @(negedge clk);
    ib.in_valid = 1'b0; ib.clear = 1'b0;
  endtask

  task automatic step_c(input logic v, input logic b, input logic clr);
    ic.in_valid = v; ic.in = b; ic.clear = clr;
    @(posedge clk); @(negedge clk);
    ic.in_valid = 1'b0; ic.clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    ia.in = 1'b0; ia.in_valid = 1'b0; ia.clear = 1'b0; ia.en_zero = 1'b1; ia.en_one = 1'b1;
    ib.in = 1'b0; ib.in_valid = 1'b0; ib.clear = 1'b0; ib.en_zero = 1'b1; ib.en_one = 1'b1;
    ic.in = 1'b0; ic.in_valid = 1'b0; ic.clear = 1'b0; ic.en_zero = 1'b1; ic.en_one = 1'b1;
    @(negedge clk); @(negedge clk);
    chk_a("reset_a", 0, 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0, 0);
    chk_c("reset_c", 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // Four zeros: hit and out rise in the cycle after the 4th sample.
    step_a(1, 0, 0); chk_a("z1", 0, 0, 1, 0, 0);
    step_a(1, 0, 0); chk_a("z2", 0, 0, 2, 0, 0);
    step_a(1, 0, 0); chk_a("z3", 0, 0, 3, 0, 0);
    step_a(1, 0, 0); chk_a("z4", 1, 0, 4, 1, 1);

    // Run continues: saturated length, no re-fire; an opposite bit leaves HIT.
    for (int i = 0; i < 5; i++) begin
      step_a(1, 0, 0); chk_a("z_sat", 1, 0, 4, 0, 1);
    end
    step_a(1, 1, 0); chk_a("break1", 0, 1, 1, 0, 1);
    step_a(0, 0, 1); chk_a("clear1", 0, 0, 0, 0, 0);

    // Gaps in in_valid do not break the run.
    for (int k = 1; k <= 3; k++) begin
      step_a(1, 0, 0); chk_a("gap_sample", 0, 0, k, 0, 0);
      repeat (3) begin
        step_a(0, 1, 0); chk_a("gap_hold", 0, 0, k, 0, 0);
      end
    end
    step_a(1, 0, 0); chk_a("gap_hit", 1, 0, 4, 1, 1);

    // Clear together with the 3rd sample wins and drops the sample.
    step_a(1, 1, 0); chk_a("pre_clr_1", 0, 1, 1, 0, 1);
    step_a(1, 0, 0); chk_a("pre_clr_2", 0, 0, 1, 0, 1);
    step_a(1, 0, 0); chk_a("pre_clr_3", 0, 0, 2, 0, 1);
    step_a(1, 0, 1); chk_a("clr_valid", 0, 0, 0, 0, 0);
    step_a(1, 0, 0); chk_a("after_clr", 0, 0, 1, 0, 0);

    // Zeros disabled: zero run is tracked but silent, ones run hits.
    step_a(0, 0, 1);
    ia.en_zero = 1'b0;
    repeat (3) step_a(1, 0, 0);
    step_a(1, 0, 0); chk_a("dis_zero", 0, 0, 4, 0, 0);
    repeat (3) step_a(1, 1, 0);
    step_a(1, 1, 0); chk_a("one_hit", 1, 1, 4, 1, 1);
    step_a(0, 0, 0); chk_a("one_hold", 1, 1, 4, 0, 1);
    ia.en_one = 1'b0;
    #1 chk_a("en_one_drop", 0, 1, 4, 0, 1);
    ia.en_one = 1'b1;
    #1 chk_a("en_one_back", 1, 1, 4, 0, 1);
    ia.en_zero = 1'b1;
    @(negedge clk);

    // RUN_LEN=6: five ones fall short, six ones hit once.
    repeat (4) step_b(1, 1, 0);
    step_b(1, 1, 0); chk_b("b_five", 0, 1, 5, 0, 0);
    step_b(1, 0, 0); chk_b("b_break", 0, 0, 1, 0, 0);
    repeat (5) step_b(1, 1, 0);
    chk_b("b_five2", 0, 1, 5, 0, 0);
    step_b(1, 1, 0); chk_b("b_six", 1, 1, 6, 1, 1);
    step_b(1, 1, 0); chk_b("b_seven", 1, 1, 6, 0, 1);

    // 2-bit counter wraps across five alternating runs: 1,2,3,0,1.
    for (int r = 0; r < 5; r++) begin
      repeat (3) step_c(1, logic'(r % 2), 0);
      step_c(1, logic'(r % 2), 0);
      chk_c("c_wrap", 1, logic'(r % 2), 4, 1, (r + 1) % 4);
    end
    step_c(1, 1, 0);
    step_c(1, 1, 0); chk_c("c_mid", 0, 1, 2, 0, 1);

    // Asynchronous reset mid-run clears everything before the next edge.
    #2 reset_n = 1'b0;
    #1 chk_c("c_async_rst", 0, 0, 0, 0, 0);
    chk_a("a_async_rst", 0, 0, 0, 0, 0);
    chk_b("b_async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
